// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_RD_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    // Bits needed to hold a count in the range 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_age_counter.sv
// Saturating age counter: counts lost arbitration rounds up to MAX.
module arb_age_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam int unsigned W = cnt_width(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over increment; increment stops at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// tracks the outstanding read and steers returning data to its owner.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 16,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic          o_if_gnt,
    output logic          o_if_rvalid,
    output logic [DW-1:0] o_if_rdata,
    input  logic          i_d_req,
    input  logic          i_d_wr,
    input  logic [AW-1:0] i_d_addr,
    input  logic [DW-1:0] i_d_wrdata,
    output logic          o_d_gnt,
    output logic          o_d_rvalid,
    output logic [DW-1:0] o_d_rdata,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_rd,
    output logic          o_mem_wr,
    output logic [DW-1:0] o_mem_wrdata,
    input  logic [DW-1:0] i_mem_rddata
);

    localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    arb_state_t       state_q, state_d;
    arb_owner_t       owner_q, owner_d;
    logic [LAT_W-1:0] lat_q,   lat_d;

    logic             age_at_max;
    logic             issue_slot;
    logic             if_win;
    logic             d_win;

    logic             if_gnt_c;
    logic             d_gnt_c;
    logic             if_rvalid_c;
    logic             d_rvalid_c;
    logic             mem_rd_c;
    logic             mem_wr_c;
    logic [AW-1:0]    mem_addr_c;
    logic [DW-1:0]    mem_wrdata_c;

    // A pending fetch that has lost MAX_WAIT rounds overrides data priority.
    arb_age_counter #(
        .MAX (MAX_WAIT)
    ) u_age (
        .clk      (clk),
        .reset    (reset),
        .inc_i    (i_if_req && !if_gnt_c),
        .clr_i    (!i_if_req || if_gnt_c),
        .at_max_o (age_at_max)
    );

    // Winner selection: only in idle or on the final cycle of a read.
    always_comb begin
        issue_slot = (state_q == S_IDLE) || (lat_q == '0);
        if_win     = issue_slot && i_if_req && (!i_d_req || age_at_max);
        d_win      = issue_slot && i_d_req && !if_win;
    end

    // Next state, read return steering and memory-port drive.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        lat_d        = lat_q;
        if_gnt_c     = 1'b0;
        d_gnt_c      = 1'b0;
        if_rvalid_c  = 1'b0;
        d_rvalid_c   = 1'b0;
        mem_rd_c     = 1'b0;
        mem_wr_c     = 1'b0;
        mem_addr_c   = '0;
        mem_wrdata_c = '0;

        if (state_q == S_RD_WAIT) begin
            if (lat_q != '0) begin
                lat_d = lat_q - LAT_W'(1);
            end else begin
                state_d = S_IDLE;
                if (owner_q == OWN_IF) begin
                    if_rvalid_c = 1'b1;
                end else begin
                    d_rvalid_c = 1'b1;
                end
            end
        end

        if (if_win) begin
            if_gnt_c   = 1'b1;
            mem_rd_c   = 1'b1;
            mem_addr_c = i_if_addr;
            state_d    = S_RD_WAIT;
            lat_d      = LAT_W'(RD_LAT - 1);
            owner_d    = OWN_IF;
        end else if (d_win) begin
            d_gnt_c    = 1'b1;
            mem_addr_c = i_d_addr;
            if (i_d_wr) begin
                mem_wr_c     = 1'b1;
                mem_wrdata_c = i_d_wrdata;
                state_d      = S_IDLE;
            end else begin
                mem_rd_c = 1'b1;
                state_d  = S_RD_WAIT;
                lat_d    = LAT_W'(RD_LAT - 1);
                owner_d  = OWN_D;
            end
        end
    end

    // State, latency and owner registers; reset aborts any outstanding read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= OWN_IF;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            lat_q   <= lat_d;
        end
    end

    // All outputs held low while reset is asserted.
    always_comb begin
        o_if_gnt     = 1'b0;
        o_d_gnt      = 1'b0;
        o_if_rvalid  = 1'b0;
        o_d_rvalid   = 1'b0;
        o_if_rdata   = '0;
        o_d_rdata    = '0;
        o_mem_rd     = 1'b0;
        o_mem_wr     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wrdata = '0;
        if (!reset) begin
            o_if_gnt     = if_gnt_c;
            o_d_gnt      = d_gnt_c;
            o_if_rvalid  = if_rvalid_c;
            o_d_rvalid   = d_rvalid_c;
            o_if_rdata   = i_mem_rddata;
            o_d_rdata    = i_mem_rddata;
            o_mem_rd     = mem_rd_c;
            o_mem_wr     = mem_wr_c;
            o_mem_addr   = mem_addr_c;
            o_mem_wrdata = mem_wrdata_c;
        end
    end

endmodule
